// File: rtl/skewed_mnk_index_gen_if.sv
// Bundle of traversal control and per-stage index signals for skewed_mnk_index_gen.
// slave is the generator side, master is the side that drives start/sizes and consumes indices.
interface skewed_mnk_index_gen_if #(
    parameter int unsigned Width        = 8,
    parameter int unsigned Chain_Length = 4
);
    logic             start_i;
    logic             en_i;
    logic [Width-1:0] M_size_i;
    logic [Width-1:0] N_size_i;
    logic [Width-1:0] K_size_i;

    logic             busy_o;
    logic [Width-1:0] M_idx_o [Chain_Length];
    logic [Width-1:0] N_idx_o [Chain_Length];
    logic [Width-1:0] K_idx_o [Chain_Length];
    logic             valid_o [Chain_Length];
    logic             last_o  [Chain_Length];
    logic             done_o;

    modport slave (
        input  start_i, en_i, M_size_i, N_size_i, K_size_i,
        output busy_o, M_idx_o, N_idx_o, K_idx_o, valid_o, last_o, done_o
    );

    modport master (
        output start_i, en_i, M_size_i, N_size_i, K_size_i,
        input  busy_o, M_idx_o, N_idx_o, K_idx_o, valid_o, last_o, done_o
    );
endinterface

// File: rtl/skewed_mnk_index_gen.sv
// Walks an M x N x K index space (K innermost) and delivers each triple down a chain of
// Chain_Length register stages, one cycle of skew per stage.
module skewed_mnk_index_gen #(
    parameter int unsigned Width        = 8,
    parameter int unsigned Chain_Length = 4
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    skewed_mnk_index_gen_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [Width-1:0] One = Width'(1);

    state_e           state_q, state_d;
    logic [Width-1:0] m_sz_q, m_sz_d, n_sz_q, n_sz_d, k_sz_q, k_sz_d;
    logic [Width-1:0] m_idx_q [Chain_Length];
    logic [Width-1:0] m_idx_d [Chain_Length];
    logic [Width-1:0] n_idx_q [Chain_Length];
    logic [Width-1:0] n_idx_d [Chain_Length];
    logic [Width-1:0] k_idx_q [Chain_Length];
    logic [Width-1:0] k_idx_d [Chain_Length];
    logic             valid_q [Chain_Length];
    logic             valid_d [Chain_Length];
    logic             last_q  [Chain_Length];
    logic             last_d  [Chain_Length];
    logic             zero_done_q, zero_done_d;

    logic             done;
    logic             any_zero;
    logic [Width-1:0] m_max, n_max, k_max;
    logic [Width-1:0] m_nxt, n_nxt, k_nxt;

    assign done     = (valid_q[Chain_Length-1] & last_q[Chain_Length-1]) | zero_done_q;
    assign any_zero = (bus.M_size_i == '0) || (bus.N_size_i == '0) || (bus.K_size_i == '0);

    // Stage-0 successor triple; compare-to-max keeps sizes up to 2^Width-1 overflow free.
    always_comb begin
        m_max = m_sz_q - One;
        n_max = n_sz_q - One;
        k_max = k_sz_q - One;
        m_nxt = m_idx_q[0];
        n_nxt = n_idx_q[0];
        k_nxt = k_idx_q[0] + One;
        if (k_idx_q[0] == k_max) begin
            k_nxt = '0;
            n_nxt = n_idx_q[0] + One;
            if (n_idx_q[0] == n_max) begin
                n_nxt = '0;
                m_nxt = m_idx_q[0] + One;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        m_sz_d      = m_sz_q;
        n_sz_d      = n_sz_q;
        k_sz_d      = k_sz_q;
        zero_done_d = zero_done_q;
        m_idx_d     = m_idx_q;
        n_idx_d     = n_idx_q;
        k_idx_d     = k_idx_q;
        valid_d     = valid_q;
        last_d      = last_q;

        if (bus.en_i) begin
            zero_done_d = 1'b0;
            for (int i = 1; i < Chain_Length; i++) begin
                m_idx_d[i] = m_idx_q[i-1];
                n_idx_d[i] = n_idx_q[i-1];
                k_idx_d[i] = k_idx_q[i-1];
                valid_d[i] = valid_q[i-1];
                last_d[i]  = last_q[i-1];
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.start_i) begin
                        m_sz_d = bus.M_size_i;
                        n_sz_d = bus.N_size_i;
                        k_sz_d = bus.K_size_i;
                        if (any_zero) begin
                            zero_done_d = 1'b1;
                        end else begin
                            state_d    = StRun;
                            m_idx_d[0] = '0;
                            n_idx_d[0] = '0;
                            k_idx_d[0] = '0;
                            valid_d[0] = 1'b1;
                            last_d[0]  = (bus.M_size_i == One) && (bus.N_size_i == One) &&
                                         (bus.K_size_i == One);
                        end
                    end
                end
                StRun: begin
                    if (last_q[0]) begin
                        valid_d[0] = 1'b0;
                        last_d[0]  = 1'b0;
                        // A single-stage chain completes on this very edge.
                        state_d    = done ? StIdle : StDrain;
                    end else begin
                        m_idx_d[0] = m_nxt;
                        n_idx_d[0] = n_nxt;
                        k_idx_d[0] = k_nxt;
                        valid_d[0] = 1'b1;
                        last_d[0]  = (m_nxt == m_max) && (n_nxt == n_max) && (k_nxt == k_max);
                    end
                end
                StDrain: begin
                    if (done) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            m_sz_q      <= '0;
            n_sz_q      <= '0;
            k_sz_q      <= '0;
            zero_done_q <= 1'b0;
            for (int i = 0; i < Chain_Length; i++) begin
                m_idx_q[i] <= '0;
                n_idx_q[i] <= '0;
                k_idx_q[i] <= '0;
                valid_q[i] <= 1'b0;
                last_q[i]  <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            m_sz_q      <= m_sz_d;
            n_sz_q      <= n_sz_d;
            k_sz_q      <= k_sz_d;
            zero_done_q <= zero_done_d;
            m_idx_q     <= m_idx_d;
            n_idx_q     <= n_idx_d;
            k_idx_q     <= k_idx_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

    assign bus.busy_o  = (state_q != StIdle);
    assign bus.done_o  = done;
    assign bus.M_idx_o = m_idx_q;
    assign bus.N_idx_o = n_idx_q;
    assign bus.K_idx_o = k_idx_q;
    assign bus.valid_o = valid_q;
    assign bus.last_o  = last_q;
endmodule

// File: tb/tb_skewed_mnk_index_gen.sv
// Bench for skewed_mnk_index_gen: directed and random traversals checked against a
// triple list built with nested loops and a per-stage delay-by-index rule.
module tb_skewed_mnk_index_gen;
    localparam int W = 8;
    localparam int L = 4;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   total = 0;
    int   bad   = 0;
    int   em[$];
    int   en[$];
    int   ek[$];

    always #5 clk_i = ~clk_i;

    skewed_mnk_index_gen_if #(.Width(W), .Chain_Length(L)) bus ();

    skewed_mnk_index_gen #(.Width(W), .Chain_Length(L)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < L; i++) begin
            check($sformatf("%s valid[%0d]", tag, i), 32'(bus.valid_o[i]), 32'd0);
            check($sformatf("%s last[%0d]", tag, i), 32'(bus.last_o[i]), 32'd0);
            check($sformatf("%s M[%0d]", tag, i), 32'(bus.M_idx_o[i]), 32'd0);
            check($sformatf("%s N[%0d]", tag, i), 32'(bus.N_idx_o[i]), 32'd0);
            check($sformatf("%s K[%0d]", tag, i), 32'(bus.K_idx_o[i]), 32'd0);
        end
        check({tag, " busy"}, 32'(bus.busy_o), 32'd0);
        check({tag, " done"}, 32'(bus.done_o), 32'd0);
    endtask

    // After e enabled edges (accepting edge = 1), stage i holds triple number e-1-i.
    task automatic check_outputs(input int e, input int t);
        int j;
        bit ev;
        for (int i = 0; i < L; i++) begin
            j  = e - 1 - i;
            ev = (j >= 0) && (j < t);
            check($sformatf("valid[%0d] e=%0d", i, e), 32'(bus.valid_o[i]), 32'(ev));
            if (ev) begin
                check($sformatf("M[%0d] e=%0d", i, e), 32'(bus.M_idx_o[i]), em[j]);
                check($sformatf("N[%0d] e=%0d", i, e), 32'(bus.N_idx_o[i]), en[j]);
                check($sformatf("K[%0d] e=%0d", i, e), 32'(bus.K_idx_o[i]), ek[j]);
                check($sformatf("last[%0d] e=%0d", i, e), 32'(bus.last_o[i]), 32'(j == t - 1));
            end
        end
        check($sformatf("busy e=%0d", e), 32'(bus.busy_o), 32'((t > 0) && (e <= t + L - 1)));
        check($sformatf("done e=%0d", e), 32'(bus.done_o),
              32'((t > 0) ? (e == t + L - 1) : (e == 1)));
    endtask

    task automatic traverse(input int m, input int n, input int k, input int stall_at,
                            input int stall_len, input bit poke, input int abort_at);
        int t, e, stalled, end_e, v0, vl, dn;
        bit fin;
        em.delete();
        en.delete();
        ek.delete();
        for (int a = 0; a < m; a++)
            for (int b = 0; b < n; b++)
                for (int c = 0; c < k; c++) begin
                    em.push_back(a);
                    en.push_back(b);
                    ek.push_back(c);
                end
        t       = m * n * k;
        end_e   = (t == 0) ? 2 : t + L;
        e       = 0;
        stalled = 0;
        v0      = 0;
        vl      = 0;
        dn      = 0;
        fin     = 1'b0;
        for (int cyc = 0; cyc < end_e + stall_len + 8 && !fin; cyc++) begin
            bus.start_i = (e == 0) || (poke && e == 2);
            if (e == 0) begin
                bus.M_size_i = W'(m);
                bus.N_size_i = W'(n);
                bus.K_size_i = W'(k);
            end else if (poke && e == 2) begin
                bus.M_size_i = W'(3);
                bus.N_size_i = W'(1);
                bus.K_size_i = W'(2);
            end else begin
                bus.M_size_i = W'($urandom);
                bus.N_size_i = W'($urandom);
                bus.K_size_i = W'($urandom);
            end
            bus.en_i = !(stall_at > 0 && e == stall_at && stalled < stall_len);
            if (!bus.en_i) stalled++;
            @(posedge clk_i);
            #1;
            if (bus.en_i) begin
                e++;
                if (bus.valid_o[0]) v0++;
                if (bus.valid_o[L-1]) vl++;
                if (bus.done_o) dn++;
            end
            check_outputs(e, t);
            if (abort_at > 0 && e == abort_at) begin
                #1 rst_ni = 1'b0;
                #1;
                check_reset("async rst");
                @(posedge clk_i);
                #1;
                check_reset("held rst");
                rst_ni = 1'b1;
                return;
            end
            if (e == end_e) fin = 1'b1;
        end
        bus.start_i = 1'b0;
        bus.en_i    = 1'b1;
        check("reached end", 32'(fin), 32'd1);
        check("stage0 count", v0, t);
        check("last stage count", vl, t);
        check("done pulses", dn, 1);
    endtask

    initial begin
        rst_ni       = 1'b0;
        bus.start_i  = 1'b0;
        bus.en_i     = 1'b1;
        bus.M_size_i = '0;
        bus.N_size_i = '0;
        bus.K_size_i = '0;
        #3;
        check_reset("por");
        @(posedge clk_i);
        #1;
        check_reset("por edge");
        rst_ni = 1'b1;

        traverse(2, 3, 2, 0, 0, 1'b0, 0);
        traverse(1, 1, 1, 0, 0, 1'b0, 0);
        traverse(3, 0, 5, 0, 0, 1'b0, 0);
        traverse(2, 2, 2, 3, 3, 1'b0, 0);
        traverse(2, 2, 2, 0, 0, 1'b1, 0);
        traverse(3, 1, 2, 0, 0, 1'b0, 0);
        traverse(2, 3, 2, 0, 0, 1'b0, 5);
        traverse(2, 3, 2, 0, 0, 1'b0, 0);
        traverse(1, 2, 255, 0, 0, 1'b0, 0);
        for (int r = 0; r < 6; r++) begin
            traverse($urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(0, 3),
                     $urandom_range(1, 6), $urandom_range(0, 3), 1'b0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
